// File: rtl/weighted_rr_arbiter_pkg.sv
// Purpose: shared state encoding and constant helpers for the weighted round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package weighted_rr_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_GRANT = 2'b01;
  localparam logic [1:0] ST_WORK  = 2'b10;

  // The fourth encoding is never entered; the FSM treats it as IDLE.
  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    GRANT  = ST_GRANT,
    WORK   = ST_WORK,
    UNUSED = 2'b11
  } state_e;

  // Ceiling log2, minimum 1 so a 2-requester index is still one bit wide.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/weighted_rr_arbiter_rr_pick.sv
// Purpose: cyclic first-set pick at or above a one-hot base, wrapping past the top index.
// Latency: combinational.
// Backpressure: none; result is valid whenever request/base are.
// Ports: request - WIDTH request vector
//        base    - one-hot search start position
//        grant   - one-hot pick, zero when request is zero
module rr_pick #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] request,
  input  logic [WIDTH-1:0] base,
  output logic [WIDTH-1:0] grant
);

  logic [2*WIDTH-1:0] dbl_req;
  logic [2*WIDTH-1:0] dbl_gnt;

  // Subtracting the base clears the first set bit at/above base and sets
  // the zeros below it; masking with the original isolates that bit. The
  // upper copy supplies the wrapped-around candidates.
  always_comb begin
    dbl_req = {request, request};
    dbl_gnt = dbl_req & ~(dbl_req - {{WIDTH{1'b0}}, base});
    grant   = dbl_gnt[WIDTH-1:0] | dbl_gnt[2*WIDTH-1:WIDTH];
  end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Purpose: weighted round-robin / fixed-priority arbiter with per-requester tenure limit.
// Latency: 2 cycles from request in IDLE to registered grant; 1 dead cycle between grants.
// Backpressure: requesters hold in_request until done; grant is revoked on drop or tenure expiry.
// Ports: in_clk/in_reset   - clock, async active-low reset
//        in_request        - per-requester request bits
//        in_weight         - CNT_W-bit tenure per requester, 0 = unlimited
//        in_mode           - 0 round robin, 1 fixed priority (index 0 highest)
//        out_grant/_id/_valid - registered one-hot grant, its index, and grant-present flag
module weighted_rr_arbiter
  import weighted_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                     in_clk,
  input  logic                     in_reset,
  input  logic [WIDTH-1:0]         in_request,
  input  logic [WIDTH*CNT_W-1:0]   in_weight,
  input  logic                     in_mode,
  output logic [WIDTH-1:0]         out_grant,
  output logic [clog2(WIDTH)-1:0]  out_grant_id,
  output logic                     out_valid
);

  localparam int ID_W = clog2(WIDTH);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic              valid_q, valid_d;

  logic [WIDTH-1:0]  pick_base;
  logic [WIDTH-1:0]  pick_grant;
  logic [ID_W-1:0]   pick_id;
  logic [CNT_W-1:0]  pick_weight;
  logic              held;
  logic              expire;

  // Fixed priority is just the cyclic pick started from index 0.
  assign pick_base = in_mode ? {{(WIDTH-1){1'b0}}, 1'b1} : base_q;

  rr_pick #(
    .WIDTH(WIDTH)
  ) u_rr_pick (
    .request(in_request),
    .base   (pick_base),
    .grant  (pick_grant)
  );

  always_comb begin
    pick_id     = '0;
    pick_weight = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pick_grant[i]) begin
        pick_id     = ID_W'(i);
        pick_weight = in_weight[i*CNT_W +: CNT_W];
      end
    end
  end

  assign held   = |(in_request & grant_q);
  // A zero counter means unlimited tenure, so only an exact 1 expires.
  assign expire = (cnt_q == CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    valid_d    = valid_q;

    case (state_q)
      GRANT: begin
        if (|in_request) begin
          grant_d    = pick_grant;
          grant_id_d = pick_id;
          valid_d    = 1'b1;
          cnt_d      = pick_weight;
          state_d    = WORK;
        end else begin
          grant_d    = '0;
          grant_id_d = '0;
          valid_d    = 1'b0;
          state_d    = IDLE;
        end
      end

      WORK: begin
        // Drop and expiry in the same cycle fall into this one branch, so
        // the base rotates exactly once.
        if (!held || expire) begin
          grant_d    = '0;
          grant_id_d = '0;
          valid_d    = 1'b0;
          cnt_d      = '0;
          base_d     = {grant_q[WIDTH-2:0], grant_q[WIDTH-1]};
          state_d    = (|in_request) ? GRANT : IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        // IDLE and the unused encoding. base_q is deliberately kept so
        // fairness carries across idle gaps.
        grant_d    = '0;
        grant_id_d = '0;
        valid_d    = 1'b0;
        cnt_d      = '0;
        state_d    = (|in_request) ? GRANT : IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q    <= IDLE;
      base_q     <= WIDTH'(1);
      cnt_q      <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      valid_q    <= valid_d;
    end
  end

  assign out_grant    = grant_q;
  assign out_grant_id = grant_id_q;
  assign out_valid    = valid_q;

endmodule

// File: doc/weighted_rr_arbiter.md
WEIGHTED_RR_ARBITER -- requirements
Module: weighted_rr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of requesters, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 4: width of each per-requester weight field.
REQ-003 SHALL have port in_clk, input, 1: clock, rising edge.
REQ-004 SHALL have port in_reset, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_request, input, WIDTH: bit i asserted means requester i wants the resource; held until done.
REQ-006 SHALL have port in_weight, input, WIDTH*CNT_W: field i, bits [i*CNT_W +: CNT_W], is the maximum tenure of requester i in cycles; 0 means unlimited.
REQ-007 SHALL have port in_mode, input, 1: 0 selects round robin, 1 selects fixed priority (index 0 highest).
REQ-008 SHALL have port out_grant, output, WIDTH, registered: one-hot or zero.
REQ-009 SHALL have port out_grant_id, output, clog2(WIDTH), registered: index of the granted requester, 0 when no grant.
REQ-010 SHALL have port out_valid, output, 1, registered: asserted exactly when out_grant is nonzero.

Function
REQ-011 SHALL implement states IDLE, GRANT and WORK, encoded 2 bits; the unused encoding SHALL behave as IDLE.
REQ-012 IDLE: out_grant=0. SHALL move to GRANT on the next edge when in_request!=0, otherwise stay in IDLE.
REQ-013 GRANT: SHALL sample in_request, in_mode and r_base, and SHALL pick the first set request at or above r_base with cyclic wrap (doubled-vector mask method).
REQ-014 GRANT: when in_mode=1, the pick SHALL use base 1 (lowest set index wins).
REQ-015 GRANT: on the next edge, SHALL register out_grant, out_grant_id and out_valid, load the tenure counter with the granted in_weight field, and go to WORK.
REQ-016 GRANT: if in_request==0 at the GRANT cycle, SHALL return to IDLE with no grant issued.
REQ-017 WORK: SHALL hold out_grant while the granted request stays high and the tenure has not expired; the counter SHALL decrement each WORK cycle when weight!=0.
REQ-018 Tenure SHALL expire in the WORK cycle where counter==1, so grant is asserted for exactly W cycles for weight W>0.
REQ-019 Release occurs when the granted request is low, or on expiry. On release, SHALL clear out_grant, out_grant_id and out_valid on the same edge, and set r_base to the circular left rotation of the released grant.
REQ-020 After release, SHALL go to GRANT if in_request!=0, else IDLE; at least one zero-grant cycle SHALL separate consecutive grants.
REQ-021 Simultaneous request drop and expiry SHALL count as a single release with identical behaviour.
REQ-022 An expired requester still requesting SHALL be re-granted only after all other active requesters are served; if it is the sole requester, it SHALL be re-granted after the dead cycle.
REQ-023 r_base SHALL be retained through IDLE, not reset, so fairness persists across idle gaps.
REQ-024 Changes to in_weight or in_mode during WORK SHALL have no effect until the next GRANT.
REQ-025 Latency from request rise in IDLE to grant visible SHALL be 2 cycles.
REQ-026 The counter SHALL be CNT_W bits and SHALL never wrap below 1 during a tenure.

Reset
REQ-027 Asserting in_reset SHALL immediately force state=IDLE, r_base=1, counter=0, out_grant=0, out_grant_id=0 and out_valid=0, including mid-tenure.
REQ-028 After in_reset deasserts, the block SHALL behave as from IDLE on the first edge.

Structure
REQ-029 A shared package SHALL hold the state encoding localparams and a clog2 constant function.
REQ-030 The cyclic pick SHALL be a combinational sub-module rr_pick (parameter WIDTH; inputs request and base; output one-hot grant), instantiated once.
REQ-031 The one-hot-to-index encoding SHALL be internal to weighted_rr_arbiter.

Verification
REQ-032 WIDTH=4, all weights 0, request=4'b1111 held with each holder dropping after 3 cycles: grants SHALL follow 0001,0010,0100,1000,0001, each 3 cycles, separated by 1 dead cycle.
REQ-033 Weights {2,1,0,3} (index 0..3), request=4'b0101 held: grant 0001 for 2 cycles, then 0100 held indefinitely (weight 0).
REQ-034 in_mode=1, request=4'b1010, weights all 1: grant SHALL always go to 0010, never 1000, repeated every 2 cycles.
REQ-035 Requester 2 the sole requester with weight 1: out_grant SHALL toggle 0100 / 0000 on alternate cycles, and out_grant_id=2 when valid.
REQ-036 in_reset asserted mid-tenure: outputs SHALL be 0 within the same cycle, and the first post-reset grant SHALL go to the lowest set request.
REQ-037 Granted request drops on the same cycle its counter reaches 1: a single release SHALL occur, and r_base SHALL advance by one position only.
